// File: rtl/key_cmd_scheduler.sv
// Converts ten held-key levels into a single valid/ready stream of key-index tokens.
// It generates press events, auto-repeat events and a space fire cooldown, and grants pending events round-robin.
module key_cmd_scheduler #(
  parameter int               CNT_W         = 24,
  parameter logic [CNT_W-1:0] REPEAT_DELAY  = CNT_W'(12500000),
  parameter logic [CNT_W-1:0] REPEAT_RATE   = CNT_W'(2500000),
  parameter logic [CNT_W-1:0] FIRE_COOLDOWN = CNT_W'(5000000),
  parameter logic [9:0]       REPEAT_MASK   = 10'h1FF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] key_level,
  input  logic       enable,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  input  logic       cmd_ready,
  output logic [7:0] drop_count,
  output logic       busy
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [9:0]       key_q_reg;
  logic [9:0]       pending_reg, pending_next;
  logic [CNT_W-1:0] timer_reg [10];
  logic [CNT_W-1:0] cooldown_reg;
  logic             cmd_valid_reg;
  logic [3:0]       cmd_code_reg;
  logic [3:0]       last_reg;
  logic [7:0]       drop_reg, drop_next;

  logic [9:0] rise;
  logic [9:0] raw_ev;
  logic [9:0] ev;
  logic       cool_drop;
  logic       load;
  logic       found;
  logic [3:0] grant_idx;
  logic [4:0] idx;
  logic [9:0] grant_mask;
  logic [9:0] coalesce;
  logic [3:0] drop_inc;
  logic [8:0] drop_sum;

  assign rise = key_level & ~key_q_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_key
      assign raw_ev[gi] = enable & (rise[gi] |
                          (key_level[gi] & REPEAT_MASK[gi] & (timer_reg[gi] == ONE)));

      always_ff @(posedge clock) begin
        if (!reset) begin
          timer_reg[gi] <= '0;
        end else if (!enable || !key_level[gi]) begin
          timer_reg[gi] <= '0;
        end else if (rise[gi]) begin
          timer_reg[gi] <= REPEAT_DELAY;
        end else if (REPEAT_MASK[gi]) begin
          if (timer_reg[gi] > ONE)
            timer_reg[gi] <= timer_reg[gi] - ONE;
          else if (timer_reg[gi] == ONE)
            timer_reg[gi] <= REPEAT_RATE;
        end
      end
    end
  endgenerate

  // Space events that arrive during cooldown are discarded before reaching pending.
  assign cool_drop = raw_ev[8] & (cooldown_reg != '0);
  assign ev        = raw_ev & ~{1'b0, cool_drop, 8'b0};
  assign load      = !cmd_valid_reg || cmd_ready;

  always_comb begin
    found     = 1'b0;
    grant_idx = 4'd0;
    idx       = 5'd0;
    for (int k = 1; k <= 10; k++) begin
      idx = 5'(last_reg) + 5'(k);
      if (idx >= 5'd10)
        idx = idx - 5'd10;
      if (!found && pending_reg[idx[3:0]]) begin
        found     = 1'b1;
        grant_idx = idx[3:0];
      end
    end
  end

  // A fresh event on the key being granted this cycle re-arms it instead of counting as a drop.
  assign grant_mask   = (load && found) ? (10'd1 << grant_idx) : 10'd0;
  assign coalesce     = ev & pending_reg & ~grant_mask;
  assign pending_next = (pending_reg & ~grant_mask) | ev;

  always_comb begin
    drop_inc = {3'b0, cool_drop};
    for (int k = 0; k < 10; k++)
      drop_inc = drop_inc + {3'b0, coalesce[k]};
    drop_sum  = {1'b0, drop_reg} + {5'b0, drop_inc};
    drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cooldown_reg <= '0;
    end else if (cmd_valid_reg && cmd_ready && (cmd_code_reg == 4'd8)) begin
      cooldown_reg <= FIRE_COOLDOWN;
    end else if (cooldown_reg != '0) begin
      cooldown_reg <= cooldown_reg - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      key_q_reg     <= '0;
      pending_reg   <= '0;
      drop_reg      <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_code_reg  <= 4'd0;
      last_reg      <= 4'd9;
    end else begin
      key_q_reg   <= key_level;
      pending_reg <= pending_next;
      drop_reg    <= drop_next;
      if (load) begin
        if (found) begin
          cmd_valid_reg <= 1'b1;
          cmd_code_reg  <= grant_idx;
          last_reg      <= grant_idx;
        end else begin
          cmd_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign cmd_valid  = cmd_valid_reg;
  assign cmd_code   = cmd_code_reg;
  assign drop_count = drop_reg;
  assign busy       = (|pending_reg) | cmd_valid_reg;

endmodule
